shift_right_seq: RTL and testbench
==================================

SHIFT_RIGHT_SEQ -- requirements
Module: shift_right_seq

Interface
REQ-001 SHALL: Clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: Rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL: InA  input  32  operand to shift right.
REQ-004 SHALL: shamt  input  32  shift amount; only shamt[4:0] is used, bits [31:5] are ignored.
REQ-005 SHALL: Arith  input  1  1 = arithmetic (sign-fill), 0 = logical (zero-fill).
REQ-006 SHALL: In_valid  input  1  request present; InA/shamt/Arith are valid.
REQ-007 SHALL: In_ready  output  1  block can accept a request.
REQ-008 SHALL: Out  output  32  shift result.
REQ-009 SHALL: Out_valid  output  1  Out holds a completed result.
REQ-010 SHALL: Out_ready  input  1  consumer accepts Out.
REQ-011 SHALL: Busy  output  1  high in SHIFT or DONE.

Function
REQ-012 SHALL: FSM states are IDLE, SHIFT and DONE.
REQ-013 SHALL: In_ready = 1 only in IDLE; a request is accepted on an edge where In_valid && In_ready.
REQ-014 SHALL: on acceptance, latch InA into the working register, shamt[4:0] and Arith into holding registers, clear the 3-bit stage counter, and enter SHIFT.
REQ-015 SHALL: in SHIFT, stage k (k = 0..4, one per cycle) right-shifts the working register by 2^k when shamt[k]=1, and passes it through unchanged otherwise.
REQ-016 SHALL: each stage fills vacated bits with the working register's bit 31 when Arith=1, and with zeros when Arith=0.
REQ-017 SHALL: latency is fixed at 5 cycles for any shamt, including 0: acceptance at edge N gives Out_valid=1 after edge N+5.
REQ-018 SHALL: after stage 4, enter DONE with Out_valid=1; Out equals the working register.
REQ-019 SHALL: in DONE, Out and Out_valid hold stable until Out_ready=1; then return to IDLE with Out_valid=0 on that edge.
REQ-020 SHALL: a new request cannot be accepted in the same cycle that DONE retires (In_ready is 0 in DONE); back-to-back throughput is one result per 7 cycles minimum.
REQ-021 SHALL: input changes during SHIFT/DONE have no effect on the in-flight operation.
REQ-022 SHALL: the result is bit-exact to InA >> shamt[4:0] (logical) or $signed(InA) >>> shamt[4:0] (arithmetic).

Reset
REQ-023 SHALL: Rst_n=0 at any time, including mid-SHIFT or in DONE, immediately forces IDLE, Out=0, Out_valid=0, Busy=0, In_ready=1, counter=0, and discards any in-flight operation.
REQ-024 SHALL: the first acceptance is possible on the first rising edge after Rst_n deasserts.

Structure
REQ-025 SHALL: the state encoding typedef (IDLE/SHIFT/DONE) and the constants STAGES=5 and DATA_W=32 live in the shared package shift_pkg.
REQ-026 SHALL: a single combinational sub-module, shift_right_stage (inputs: data, stage index, enable bit, Arith; output: data), is instantiated once and driven by the stage counter.
REQ-027 SHALL: the implementation contains no latches and no combinational path from In_valid to In_ready.

Verification
REQ-028 SHALL: InA=0x80000000, shamt=4, Arith=0 -> Out=0x08000000, with Out_valid exactly 5 cycles after acceptance.
REQ-029 SHALL: InA=0x80000000, shamt=31, Arith=1 -> Out=0xFFFFFFFF; with Arith=0 -> Out=0x00000001.
REQ-030 SHALL: InA=0x12345678, shamt=0x00000024 -> Out=0x01234567 (only the low 5 bits are used); shamt=0 -> Out=0x12345678 after 5 cycles.
REQ-031 SHALL: Out_ready held 0 for 10 cycles in DONE -> Out and Out_valid stay stable and In_ready stays 0; Out_ready=1 -> IDLE on the next edge.
REQ-032 SHALL: Rst_n pulsed low during stage 2 -> Out_valid=0 and In_ready=1 immediately; the next request InA=0xF0000000, shamt=8, Arith=1 -> Out=0xFFF00000.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types and constants for the multi-cycle barrel right shifter.
package shift_pkg;

  localparam int DATA_W = 32;
  localparam int STAGES = 5;
  localparam int CNT_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Shift distance applied by stage k when its shamt bit is set.
  function automatic logic [4:0] stage_dist(input logic [CNT_W-1:0] k);
    logic [4:0] d;
    d = '0;
    case (k)
      3'd0: d = 5'd1;
      3'd1: d = 5'd2;
      3'd2: d = 5'd4;
      3'd3: d = 5'd8;
      3'd4: d = 5'd16;
      default: d = 5'd0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/shift_right_seq_if.sv
// Request/response bundle of the sequential right shifter.
// Handshake: a request transfers on a rising edge where In_valid && In_ready;
// a result transfers on a rising edge where Out_valid && Out_ready.
interface shift_right_seq_if;
  import shift_pkg::*;

  logic [DATA_W-1:0] InA;
  logic [DATA_W-1:0] shamt;
  logic              Arith;
  logic              In_valid;
  logic              In_ready;
  logic [DATA_W-1:0] Out;
  logic              Out_valid;
  logic              Out_ready;
  logic              Busy;

  modport master (
    output InA, shamt, Arith, In_valid, Out_ready,
    input  In_ready, Out, Out_valid, Busy
  );

  modport slave (
    input  InA, shamt, Arith, In_valid, Out_ready,
    output In_ready, Out, Out_valid, Busy
  );
endinterface

// File: rtl/shift_right_stage.sv
// One log-shifter stage: shifts by 2^stage when enabled, sign- or zero-filling.
module shift_right_stage
  import shift_pkg::*;
(
  input  logic [DATA_W-1:0] i_data,
  input  logic [CNT_W-1:0]  i_stage,
  input  logic              i_en,
  input  logic              i_arith,
  output logic [DATA_W-1:0] o_data
);

  logic [4:0] w_dist;

  assign w_dist = i_en ? stage_dist(i_stage) : 5'd0;

  assign o_data = i_arith ? DATA_W'($signed(i_data) >>> w_dist)
                          : (i_data >> w_dist);

endmodule

// File: rtl/shift_right_seq.sv
// Sequential right shifter: one log-shifter stage per cycle, fixed 5-cycle latency,
// result held in DONE until the consumer accepts it.
module shift_right_seq
  import shift_pkg::*;
(
  input  logic              Clk,
  input  logic              Rst_n,
  shift_right_seq_if.slave  bus,
  output state_t            o_dbg_state
);

  state_t            r_state;
  state_t            w_next;
  logic [DATA_W-1:0] r_work;
  logic [4:0]        r_shamt;
  logic              r_arith;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] w_stage_out;
  logic              w_stage_en;
  logic              w_accept;
  logic              w_unused_shamt;

  assign w_unused_shamt = ^bus.shamt[DATA_W-1:5];

  // In_ready depends on state only, so there is no In_valid -> In_ready path.
  assign bus.In_ready  = (r_state == IDLE);
  assign bus.Out_valid = (r_state == DONE);
  assign bus.Busy      = (r_state != IDLE);
  assign bus.Out       = (r_state == DONE) ? r_work : '0;
  assign o_dbg_state   = r_state;

  assign w_accept   = (r_state == IDLE) && bus.In_valid;
  assign w_stage_en = (r_cnt < CNT_W'(STAGES)) ? r_shamt[r_cnt] : 1'b0;

  shift_right_stage u_stage (
    .i_data  (r_work),
    .i_stage (r_cnt),
    .i_en    (w_stage_en),
    .i_arith (r_arith),
    .o_data  (w_stage_out)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.In_valid) w_next = SHIFT;
      SHIFT:   if (r_cnt == CNT_W'(STAGES - 1)) w_next = DONE;
      DONE:    if (bus.Out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operands are captured only on acceptance, so later input activity is ignored.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_work  <= '0;
      r_shamt <= '0;
      r_arith <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_work  <= bus.InA;
      r_shamt <= bus.shamt[4:0];
      r_arith <= bus.Arith;
      r_cnt   <= '0;
    end else if (r_state == SHIFT) begin
      r_work  <= w_stage_out;
      r_cnt   <= r_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_shift_right_seq.sv
// Randomized and directed bench for shift_right_seq against a plain-arithmetic model.
module tb_shift_right_seq;
  import shift_pkg::*;

  logic   Clk;
  logic   Rst_n;
  state_t dbg_state;

  shift_right_seq_if bus();

  shift_right_seq dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_err    = 0;
  logic [31:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [31:0] s,
                                            input bit ar);
    int n;
    n = int'(s % 32);
    if (ar) return $signed(a) >>> n;
    return a >> n;
  endfunction

  // ---------------- drivers ----------------
  task automatic scramble_inputs();
    bus.InA      = $urandom;
    bus.shamt    = $urandom;
    bus.Arith    = 1'($urandom_range(0, 1));
    bus.In_valid = 1'($urandom_range(0, 1));
  endtask

  // Presents a request and lets it be taken on the next rising edge.
  task automatic accept(input logic [31:0] a, input logic [31:0] s, input bit ar);
    check_eq("in_ready_before_req", 32'(bus.In_ready), 32'd1);
    bus.InA      = a;
    bus.shamt    = s;
    bus.Arith    = ar;
    bus.In_valid = 1'b1;
    bus.Out_ready = 1'b0;
    @(posedge Clk);
    #1;
    bus.In_valid = 1'b0;
    exp_q.push_back(ref_shift(a, s, ar));
  endtask

  // Counts edges from acceptance to Out_valid while hammering the inputs.
  task automatic wait_result(output int lat);
    lat = 0;
    while (lat < 20) begin
      scramble_inputs();
      @(posedge Clk);
      lat++;
      #1;
      if (bus.Out_valid) break;
    end
    if (!bus.Out_valid) check_eq("result_timeout", 32'(lat), 32'd5);
  endtask

  task automatic retire(input int hold);
    logic [31:0] exp;
    exp = exp_q.pop_front();
    check_eq("out_data", bus.Out, exp);
    check_eq("busy_done", 32'(bus.Busy), 32'd1);
    for (int i = 0; i < hold; i++) begin
      scramble_inputs();
      @(posedge Clk);
      #1;
      check_eq("hold_out", bus.Out, exp);
      check_eq("hold_valid", 32'(bus.Out_valid), 32'd1);
      check_eq("hold_in_ready", 32'(bus.In_ready), 32'd0);
    end
    bus.Out_ready = 1'b1;
    @(posedge Clk);
    #1;
    bus.Out_ready = 1'b0;
    bus.In_valid  = 1'b0;
    check_eq("retire_valid", 32'(bus.Out_valid), 32'd0);
    check_eq("retire_in_ready", 32'(bus.In_ready), 32'd1);
    check_eq("retire_busy", 32'(bus.Busy), 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] s,
                        input bit ar, input int hold);
    int lat;
    accept(a, s, ar);
    wait_result(lat);
    check_eq({tag, "_latency"}, 32'(lat), 32'd5);
    retire(hold);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    Rst_n         = 1'b0;
    bus.InA       = '0;
    bus.shamt     = '0;
    bus.Arith     = 1'b0;
    bus.In_valid  = 1'b0;
    bus.Out_ready = 1'b0;
    #12;
    check_eq("rst_out", bus.Out, 32'd0);
    check_eq("rst_valid", 32'(bus.Out_valid), 32'd0);
    check_eq("rst_in_ready", 32'(bus.In_ready), 32'd1);
    check_eq("rst_busy", 32'(bus.Busy), 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge Clk);
    Rst_n = 1'b1;

    // Directed corner cases; the first goes in on the first edge after reset.
    run_op("msb_log4",   32'h8000_0000, 32'd4,          1'b0, 0);
    run_op("msb_ari31",  32'h8000_0000, 32'd31,         1'b1, 0);
    run_op("msb_log31",  32'h8000_0000, 32'd31,         1'b0, 0);
    run_op("hi_bits",    32'h1234_5678, 32'h0000_0024,  1'b0, 0);
    run_op("zero_shamt", 32'h1234_5678, 32'd0,          1'b1, 0);
    run_op("long_hold",  32'hC0DE_F00D, 32'd7,          1'b1, 10);

    // Asynchronous reset while stage 2 is being applied.
    accept(32'hDEAD_BEEF, 32'd21, 1'b1);
    repeat (2) @(posedge Clk);
    #1;
    Rst_n = 1'b0;
    #1;
    exp_q.delete();
    check_eq("midrst_valid", 32'(bus.Out_valid), 32'd0);
    check_eq("midrst_in_ready", 32'(bus.In_ready), 32'd1);
    check_eq("midrst_busy", 32'(bus.Busy), 32'd0);
    check_eq("midrst_out", bus.Out, 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    accept(32'hF000_0000, 32'd8, 1'b1);
    wait_result(lat);
    check_eq("post_rst_latency", 32'(lat), 32'd5);
    check_eq("post_rst_value", bus.Out, 32'hFFF0_0000);
    retire(0);

    // Random traffic.
    for (int i = 0; i < 40; i++) begin
      run_op("rand", $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
